// File: rtl/mem_burst_arbiter_2ch.sv
// rtl/mem_burst_arbiter_2ch.sv - two-channel round-robin burst arbiter for a shared memory
//
// Shares one 2**AW-entry memory with RD_LAT read latency between two requesters.
// Whole bursts are arbitrated round-robin. A burst issues one beat per cycle.
// Returned read beats are routed to the channel that owns the burst.
//
// Ports (N = 0,1):
//   clk, rst              clock, synchronous active-high reset
//   reqN/cmdN/addrN/lenN  burst request; cmd/addr/len are sampled at grant
//   wdataN                write data for the current beat, consumed when wbeatN=1
//   ackN                  pulse on the first issued beat of an accepted burst
//   wbeatN                write beat consumed this cycle
//   rd_validN             rd_data carries a read beat for channel N
//   doneN                 pulse when the burst is fully complete
//   rd_data               read data broadcast (mem_rd_data pass-through)
//   mem_*                 memory command/address/data interface
module mem_burst_arbiter_2ch #(
  parameter int DW     = 512,
  parameter int AW     = 10,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] len0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          wbeat0,
  output logic          rd_valid0,
  output logic          done0,
  input  logic          req1,
  input  logic          cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          wbeat1,
  output logic          rd_valid1,
  output logic          done1,
  output logic [DW-1:0] rd_data,
  output logic          mem_cmd_en,
  output logic          mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          mem_rd_data_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          last_grant_q;
  logic          owner_q;
  logic          cmd_q;
  logic [AW-1:0] cur_addr_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] beat_cnt_q;
  // Index 0 is the newest read issue; index RD_LAT-1 lines up with mem_rd_data_valid.
  logic [RD_LAT-1:0] tag_v_q;
  logic [RD_LAT-1:0] tag_ch_q;
  logic [1:0]    done_w_q;

  logic grant;
  logic grant_ch;
  logic in_burst;
  logic last_beat;
  logic issue_rd;
  logic rd_hit;
  logic drain_done;

  assign in_burst   = (state_q == BURST);
  assign last_beat  = (beat_cnt_q == len_q);
  assign issue_rd   = in_burst & ~cmd_q;
  assign rd_hit     = mem_rd_data_valid & tag_v_q[RD_LAT-1];
  // The burst is finished when the returning beat is the only read still in flight.
  assign drain_done = (state_q == DRAIN) & rd_hit & ~(|(tag_v_q << 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_ch = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant    = 1'b1;
          // On a tie, the channel that did not win last time goes first.
          grant_ch = (req0 & req1) ? ~last_grant_q : req1;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (last_beat) begin
          state_d = cmd_q ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_q        <= 1'b0;
      cur_addr_q   <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      tag_v_q      <= '0;
      tag_ch_q     <= '0;
      done_w_q     <= '0;
    end else begin
      tag_v_q  <= (tag_v_q << 1) | RD_LAT'(issue_rd);
      tag_ch_q <= (tag_ch_q << 1) | RD_LAT'(owner_q);
      done_w_q <= {in_burst & last_beat & cmd_q & owner_q,
                   in_burst & last_beat & cmd_q & ~owner_q};
      if (grant) begin
        last_grant_q <= grant_ch;
        owner_q      <= grant_ch;
        cmd_q        <= grant_ch ? cmd1 : cmd0;
        cur_addr_q   <= grant_ch ? addr1 : addr0;
        len_q        <= grant_ch ? len1 : len0;
        beat_cnt_q   <= '0;
      end else if (in_burst) begin
        cur_addr_q <= cur_addr_q + 1'b1;
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  assign mem_cmd_en  = in_burst;
  assign mem_cmd     = in_burst & cmd_q;
  assign mem_addr    = in_burst ? cur_addr_q : '0;
  assign mem_wr_data = in_burst ? (owner_q ? wdata1 : wdata0) : '0;

  assign ack0   = in_burst & (beat_cnt_q == '0) & ~owner_q;
  assign ack1   = in_burst & (beat_cnt_q == '0) & owner_q;
  assign wbeat0 = in_burst & cmd_q & ~owner_q;
  assign wbeat1 = in_burst & cmd_q & owner_q;

  assign rd_data   = mem_rd_data;
  assign rd_valid0 = rd_hit & ~tag_ch_q[RD_LAT-1];
  assign rd_valid1 = rd_hit & tag_ch_q[RD_LAT-1];

  assign done0 = done_w_q[0] | (drain_done & ~owner_q);
  assign done1 = done_w_q[1] | (drain_done & owner_q);

endmodule
